// File: rtl/pmem_wb_sched.sv
// Write-back scheduler: buffers dirty-line writes so read misses reach pmem first.
// Optional: define PMEM_WB_COALESCE_EN to merge writes to an already-buffered line.
module pmem_wb_sched #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_read,
  input  logic                    up_write,
  input  logic [31:0]             up_address,
  input  logic [LINE_W-1:0]       up_wdata,
  output logic                    up_resp,
  output logic [LINE_W-1:0]       up_rdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [31:0]             pmem_address,
  output logic [LINE_W-1:0]       pmem_wdata,
  input  logic                    pmem_resp,
  input  logic [LINE_W-1:0]       pmem_rdata,
  output logic                    wb_empty,
  output logic [$clog2(DEPTH):0]  wb_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RESP, RD_MEM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     head_q, tail_q;
  logic [AW:0]       count_q;
  logic [DEPTH-1:0]  valid_q;
  logic [26:0]       tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] rdata_q, rdata_d;

  logic [26:0]   up_tag;
  logic          unused_addr_lsb;
  logic          full;
  logic          hit;
  logic [AW-1:0] hit_idx, scan_idx;
  logic          alloc, pop, wr_en, latch_en;
  logic [AW-1:0] wr_idx;

  assign up_tag          = up_address[31:5];
  assign unused_addr_lsb = ^up_address[4:0];
  assign full            = (count_q == (AW+1)'(DEPTH));

  // Scan oldest to youngest so the last match wins: the youngest copy of a line.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + AW'(i);
      if (valid_q[scan_idx] && (tag_q[scan_idx] == up_tag)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    alloc    = 1'b0;
    pop      = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = tail_q;
    latch_en = 1'b0;
    rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (up_read) begin
          if (hit) begin
            latch_en = 1'b1;
            rdata_d  = data_q[hit_idx];
            state_d  = RESP;
          end else begin
            state_d = RD_MEM;
          end
        end else if (up_write) begin
`ifdef PMEM_WB_COALESCE_EN
          if (hit) begin
            wr_en    = 1'b1;
            wr_idx   = hit_idx;
            latch_en = 1'b1;
            state_d  = RESP;
          end else
`endif
          if (!full) begin
            alloc    = 1'b1;
            wr_en    = 1'b1;
            latch_en = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = DRAIN;
          end
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      RESP:   state_d = IDLE;
      RD_MEM: if (pmem_resp) state_d = IDLE;
      DRAIN: begin
        if (pmem_resp) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    up_resp      = 1'b0;
    up_rdata     = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      RESP: begin
        up_resp  = 1'b1;
        up_rdata = rdata_q;
      end
      RD_MEM: begin
        pmem_read    = 1'b1;
        pmem_address = {up_tag, 5'b0};
        if (pmem_resp) begin
          up_resp  = 1'b1;
          up_rdata = pmem_rdata;
        end
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[head_q], 5'b0};
        pmem_wdata   = data_q[head_q];
      end
      default: ;
    endcase
  end

  // Allocation and pop are mutually exclusive: each needs a different FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      rdata_q <= '0;
    end else begin
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + AW'(1);
        count_q         <= count_q + (AW+1)'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + AW'(1);
        count_q         <= count_q - (AW+1)'(1);
      end
      if (latch_en) rdata_q <= rdata_d;
    end
  end

  // NOTE: line storage has no reset; the valid bits alone say which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= up_tag;
      data_q[wr_idx] <= up_wdata;
    end
  end

  assign wb_count = count_q;
  assign wb_empty = (count_q == '0) && (state_q != DRAIN);

endmodule

// File: tb/tb_pmem_wb_sched.sv
// Directed bench for pmem_wb_sched with a small cacheline-adaptor model that logs every pmem access.
module tb_pmem_wb_sched;

  logic         clk, rst_n;
  logic         up_read, up_write, up_resp;
  logic [31:0]  up_address;
  logic [255:0] up_wdata, up_rdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         wb_empty;
  logic [2:0]   wb_count;

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;

  typedef struct {
    logic         is_wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_op_t;
  mem_op_t log_q[$];

  pmem_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .up_read(up_read), .up_write(up_write), .up_address(up_address), .up_wdata(up_wdata),
    .up_resp(up_resp), .up_rdata(up_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .wb_empty(wb_empty), .wb_count(wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] pat(input logic [31:0] s);
    return {8{s}};
  endfunction

  function automatic logic [255:0] mem_val(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  // Adaptor model: answers any request after three cycles with a one-cycle pmem_resp.
  initial begin : adaptor
    int lat;
    mem_op_t op;
    lat = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_read) rd_cycles++;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        lat = 0;
      end else if (rst_n && (pmem_read || pmem_write)) begin
        if (lat == 2) begin
          pmem_resp = 1'b1;
          pmem_rdata = pmem_read ? mem_val(pmem_address) : '0;
          op.is_wr = pmem_write;
          op.addr = pmem_address;
          op.data = pmem_wdata;
          log_q.push_back(op);
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // One upstream transaction, held until up_resp. Outputs are sampled 2 time units after negedge.
  task automatic do_req(input logic rd, input logic [31:0] a, input logic [255:0] d,
                        output logic [255:0] rdata, output int lat, output logic with_pmem);
    logic got;
    got = 1'b0;
    lat = 0;
    rdata = '0;
    with_pmem = 1'b0;
    up_read = rd;
    up_write = !rd;
    up_address = a;
    up_wdata = d;
    while (!got && lat < 300) begin
      @(negedge clk);
      #2;
      lat++;
      if (up_resp) begin
        got = 1'b1;
        rdata = up_rdata;
        with_pmem = pmem_resp;
      end
    end
    up_read = 1'b0;
    up_write = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_timeout addr=%h got no up_resp, required one", a);
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    #2;
    while (!wb_empty && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (wb_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain_timeout wb_empty=%b required 1", name, wb_empty);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_hold_wb_empty got=%b exp=1", wb_empty); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    checks++; if (up_resp !== 1'b0) begin errors++; $display("FAIL reset_up_resp got=%b exp=0", up_resp); end
    checks++; if (up_rdata !== '0) begin errors++; $display("FAIL reset_up_rdata got=%h exp=0", up_rdata); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got=%b exp=0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
    checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL reset_pmem_address got=%h exp=0", pmem_address); end
    checks++; if (pmem_wdata !== '0) begin errors++; $display("FAIL reset_pmem_wdata got=%h exp=0", pmem_wdata); end
    checks++; if (wb_count !== 3'd0) begin errors++; $display("FAIL reset_wb_count got=%0d exp=0", wb_count); end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_wb_empty got=%b exp=1", wb_empty); end
    checks++; if (log_q.size() != 0 || rd_cycles != 0) begin errors++; $display("FAIL reset_no_pmem got=%0d ops exp=0", log_q.size()); end
  endtask

  task automatic test_write_read_hit();
    logic [255:0] r;
    int lat, rd0;
    logic wp;
    log_q.delete();
    do_req(1'b0, 32'h1000, pat(32'hAAAA_0001), r, lat, wp);
    checks++; if (lat < 1 || lat > 2) begin errors++; $display("FAIL hit_write_latency got=%0d exp=1..2", lat); end
    checks++; if (wb_count !== 3'd1) begin errors++; $display("FAIL hit_wb_count got=%0d exp=1", wb_count); end
    rd0 = rd_cycles;
    do_req(1'b1, 32'h1010, '0, r, lat, wp);
    checks++; if (r !== pat(32'hAAAA_0001)) begin errors++; $display("FAIL hit_rdata got=%h exp=%h", r, pat(32'hAAAA_0001)); end
    checks++; if (rd_cycles != rd0) begin errors++; $display("FAIL hit_no_pmem_read got=%0d exp=%0d", rd_cycles, rd0); end
    checks++; if (lat < 1 || lat > 2) begin errors++; $display("FAIL hit_read_latency got=%0d exp=1..2", lat); end
    wait_empty("hit");
    checks++;
    if (log_q.size() != 1 || !log_q[0].is_wr || log_q[0].addr !== 32'h1000 || log_q[0].data !== pat(32'hAAAA_0001)) begin
      errors++; $display("FAIL hit_drain got=%0d ops exp=1 write of 0x1000", log_q.size());
    end
  endtask

  task automatic test_read_miss();
    logic [255:0] r;
    int lat;
    logic wp;
    log_q.delete();
    do_req(1'b0, 32'h2000, pat(32'hBBBB_0002), r, lat, wp);
    do_req(1'b1, 32'h3014, '0, r, lat, wp);
    checks++;
    if (log_q.size() < 1 || log_q[0].is_wr || log_q[0].addr !== 32'h3000) begin
      errors++; $display("FAIL miss_first_op got=%0d ops exp read of 0x3000 first", log_q.size());
    end
    checks++; if (wp !== 1'b1) begin errors++; $display("FAIL miss_resp_with_pmem got=%b exp=1", wp); end
    checks++; if (r !== mem_val(32'h3000)) begin errors++; $display("FAIL miss_rdata got=%h exp=%h", r, mem_val(32'h3000)); end
    wait_empty("miss");
    checks++;
    if (log_q.size() != 2 || !log_q[1].is_wr || log_q[1].addr !== 32'h2000 || log_q[1].data !== pat(32'hBBBB_0002)) begin
      errors++; $display("FAIL miss_drain got=%0d ops exp=2 with write 0x2000 last", log_q.size());
    end
  endtask

  task automatic test_full_stall();
    logic [255:0] r;
    int lat;
    logic wp;
    log_q.delete();
    for (int i = 0; i < 4; i++) do_req(1'b0, 32'(i + 1) * 32'h100, pat(32'hD000_0000 + 32'(i)), r, lat, wp);
    checks++; if (wb_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", wb_count); end
    do_req(1'b0, 32'h500, pat(32'hD000_0004), r, lat, wp);
    checks++;
    if (log_q.size() != 1 || !log_q[0].is_wr || log_q[0].addr !== 32'h100) begin
      errors++; $display("FAIL full_first_drain got=%0d ops exp=1 write of 0x100", log_q.size());
    end
    checks++; if (wb_count !== 3'd4) begin errors++; $display("FAIL full_count_after got=%0d exp=4", wb_count); end
    checks++; if (lat <= 2) begin errors++; $display("FAIL full_stalled latency got=%0d exp>2", lat); end
    wait_empty("full");
    checks++; if (log_q.size() != 5) begin errors++; $display("FAIL full_drain_count got=%0d exp=5", log_q.size()); end
    for (int i = 1; i < 5 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== 32'(i + 1) * 32'h100 || log_q[i].data !== pat(32'hD000_0000 + 32'(i))) begin
        errors++; $display("FAIL full_order_%0d got=%h exp=%h", i, log_q[i].addr, 32'(i + 1) * 32'h100);
      end
    end
  endtask

  task automatic test_idle_drain_wrap();
    logic [255:0] r;
    int lat;
    logic wp;
    log_q.delete();
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, 32'h8000 + 32'(i) * 32'h20, pat(32'hE000_0000 + 32'(i)), r, lat, wp);
      if (i % 2 == 1) repeat (12) @(negedge clk);
    end
    wait_empty("wrap");
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL wrap_count got=%0d exp=6", log_q.size()); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      checks++;
      if (!log_q[i].is_wr || log_q[i].addr !== 32'h8000 + 32'(i) * 32'h20 || log_q[i].data !== pat(32'hE000_0000 + 32'(i))) begin
        errors++; $display("FAIL wrap_order_%0d got=%h exp=%h", i, log_q[i].addr, 32'h8000 + 32'(i) * 32'h20);
      end
    end
    checks++; if (wb_count !== 3'd0) begin errors++; $display("FAIL wrap_wb_count got=%0d exp=0", wb_count); end
  endtask

  task automatic test_coalesce();
    logic [255:0] r;
    int lat;
    logic wp;
    log_q.delete();
    do_req(1'b0, 32'h40, pat(32'hA0A0_0040), r, lat, wp);
    do_req(1'b0, 32'h40, pat(32'hB0B0_0040), r, lat, wp);
`ifdef PMEM_WB_COALESCE_EN
    checks++; if (wb_count !== 3'd1) begin errors++; $display("FAIL coal_wb_count got=%0d exp=1", wb_count); end
`else
    checks++; if (wb_count !== 3'd2) begin errors++; $display("FAIL coal_wb_count got=%0d exp=2", wb_count); end
`endif
    do_req(1'b1, 32'h40, '0, r, lat, wp);
    checks++; if (r !== pat(32'hB0B0_0040)) begin errors++; $display("FAIL coal_rdata got=%h exp=%h", r, pat(32'hB0B0_0040)); end
    wait_empty("coal");
`ifdef PMEM_WB_COALESCE_EN
    checks++;
    if (log_q.size() != 1 || log_q[0].data !== pat(32'hB0B0_0040)) begin
      errors++; $display("FAIL coal_drain got=%0d ops exp=1 write of B", log_q.size());
    end
`else
    checks++;
    if (log_q.size() != 2 || log_q[0].data !== pat(32'hA0A0_0040) || log_q[1].data !== pat(32'hB0B0_0040)) begin
      errors++; $display("FAIL coal_drain got=%0d ops exp=2 writes A then B", log_q.size());
    end
`endif
  endtask

  task automatic test_reset_abort();
    logic [255:0] r;
    int lat;
    logic wp;
    do_req(1'b0, 32'h600, pat(32'h0600_0600), r, lat, wp);
    do_req(1'b0, 32'h700, pat(32'h0700_0700), r, lat, wp);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    log_q.delete();
    repeat (20) @(negedge clk);
    #2;
    checks++; if (wb_count !== 3'd0) begin errors++; $display("FAIL abort_wb_count got=%0d exp=0", wb_count); end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL abort_wb_empty got=%b exp=1", wb_empty); end
    checks++; if (log_q.size() != 0) begin errors++; $display("FAIL abort_no_drain got=%0d ops exp=0", log_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    up_read = 1'b0;
    up_write = 1'b0;
    up_address = '0;
    up_wdata = '0;
    test_reset();
    test_write_read_hit();
    test_read_miss();
    test_full_stall();
    test_idle_drain_wrap();
    test_coalesce();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
